// File: rtl/rst_sequencer_if.sv
// Reset sequencer signal bundle: lock/request inputs toward the sequencer,
// staged reset outputs, cause register and debug state back out.
// master = SoC/clock side that drives requests, slave = rst_sequencer.
interface rst_sequencer_if;
    logic       pll_locked_i;
    logic       sw_rst_req_i;
    logic       dbg_rst_req_i;
    logic       wdog_kick_i;
    logic       cause_clr_i;
    logic       rst_periph_no;
    logic       rst_core_no;
    logic [3:0] rst_cause_o;
    logic [2:0] seq_state_o;

    modport master (
        output pll_locked_i, sw_rst_req_i, dbg_rst_req_i, wdog_kick_i, cause_clr_i,
        input  rst_periph_no, rst_core_no, rst_cause_o, seq_state_o
    );

    modport slave (
        input  pll_locked_i, sw_rst_req_i, dbg_rst_req_i, wdog_kick_i, cause_clr_i,
        output rst_periph_no, rst_core_no, rst_cause_o, seq_state_o
    );
endinterface

// File: rtl/rst_sequencer.sv
// Staged reset controller: qualifies PLL lock, holds reset for a settle time,
// releases peripheral reset before core reset, re-sequences on lock loss,
// software request, debug request or watchdog expiry, and keeps a sticky cause.
// Optional watchdog is compiled in with RST_SEQ_WDOG_EN.
//
// state     | meaning
// WAIT_LOCK | waiting for synchronized PLL lock, both resets asserted
// HOLD      | settle time after lock, both resets asserted
// PERIPH    | peripheral reset released, core reset still asserted
// RUN       | both resets released
// DBG       | debug module holds both resets asserted
module rst_sequencer #(
    parameter int HoldCycles = 1024,
    parameter int StageGap   = 16,
    parameter int WdogCycles = 2**24
) (
    input  logic           clk_sys_i,
    input  logic           rst_sys_ni,
    rst_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        HOLD      = 3'd1,
        PERIPH    = 3'd2,
        RUN       = 3'd3,
        DBG       = 3'd4
    } state_e;

    localparam int CntMax = (HoldCycles > StageGap) ? HoldCycles : StageGap;
    localparam int CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] HoldLoad  = CntW'(HoldCycles - 1);
    localparam logic [CntW-1:0] StageLoad = CntW'(StageGap - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            lock_meta_q, locked_sync;
    logic            lock_evt, dbg_evt, sw_evt, wdog_evt;
    logic            periph_n_q, core_n_q;
    logic [3:0]      cause_q;

    // Two-flop synchronizer for the asynchronous PLL lock indication.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            lock_meta_q <= 1'b0;
            locked_sync <= 1'b0;
        end else begin
            lock_meta_q <= bus.pll_locked_i;
            locked_sync <= lock_meta_q;
        end
    end

`ifdef RST_SEQ_WDOG_EN
    localparam int WdogW = $clog2(WdogCycles);
    logic [WdogW-1:0] wdog_q;

    // Watchdog counts RUN cycles; held at zero outside RUN and on every kick.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            wdog_q <= '0;
        end else if (state_q != RUN || bus.wdog_kick_i) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_q + WdogW'(1);
        end
    end

    assign wdog_evt = (state_q == RUN) && !bus.wdog_kick_i &&
                      (wdog_q == WdogW'(WdogCycles - 1));
`else
    localparam int UnusedWdogCycles = WdogCycles;
    logic unused_wdog_kick;
    assign unused_wdog_kick = bus.wdog_kick_i;
    assign wdog_evt         = 1'b0;
`endif

    // Exit events; dbg only counts on entry so a held request does not re-trigger.
    always_comb begin
        lock_evt = (state_q != WAIT_LOCK) && !locked_sync;
        dbg_evt  = (state_q != WAIT_LOCK) && (state_q != DBG) && bus.dbg_rst_req_i;
        sw_evt   = ((state_q == PERIPH) || (state_q == RUN)) && bus.sw_rst_req_i;
    end

    // Next-state selection in event priority order, then counter reload/decrement.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (lock_evt) begin
            state_d = WAIT_LOCK;
        end else if (dbg_evt) begin
            state_d = DBG;
        end else if (wdog_evt || sw_evt) begin
            state_d = HOLD;
        end else begin
            case (state_q)
                WAIT_LOCK: if (locked_sync)            state_d = HOLD;
                HOLD:      if (cnt_q == '0)            state_d = PERIPH;
                PERIPH:    if (cnt_q == '0)            state_d = RUN;
                RUN:                                   state_d = RUN;
                DBG:       if (!bus.dbg_rst_req_i)     state_d = HOLD;
                default:                               state_d = WAIT_LOCK;
            endcase
        end

        if (state_d != state_q) begin
            if (state_d == HOLD)        cnt_d = HoldLoad;
            else if (state_d == PERIPH) cnt_d = StageLoad;
            else                        cnt_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    // State, counter and registered reset outputs all move on the same edge.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            state_q    <= WAIT_LOCK;
            cnt_q      <= '0;
            periph_n_q <= 1'b0;
            core_n_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            periph_n_q <= (state_d == PERIPH) || (state_d == RUN);
            core_n_q   <= (state_d == RUN);
        end
    end

    // Sticky cause register; a new event beats a clear in the same cycle.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            cause_q <= '0;
        end else begin
            cause_q <= (cause_q & ~{4{bus.cause_clr_i}}) |
                       {wdog_evt, dbg_evt, sw_evt, lock_evt};
        end
    end

    assign bus.rst_periph_no = periph_n_q;
    assign bus.rst_core_no   = core_n_q;
    assign bus.rst_cause_o   = cause_q;
    assign bus.seq_state_o   = state_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer with HoldCycles=8, StageGap=4, WdogCycles=16.
// Watchdog expectations follow RST_SEQ_WDOG_EN.
module tb_rst_sequencer;

`ifdef RST_SEQ_WDOG_EN
    localparam bit WdogOn = 1'b1;
`else
    localparam bit WdogOn = 1'b0;
`endif

    logic clk_sys_i  = 1'b0;
    logic rst_sys_ni = 1'b0;
    int   checks = 0;
    int   errors = 0;

    rst_sequencer_if bus ();

    rst_sequencer #(
        .HoldCycles (8),
        .StageGap   (4),
        .WdogCycles (16)
    ) dut (
        .clk_sys_i  (clk_sys_i),
        .rst_sys_ni (rst_sys_ni),
        .bus        (bus.slave)
    );

    always #5 clk_sys_i = ~clk_sys_i;

    task automatic tick();
        @(posedge clk_sys_i);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rst(input string tag, input logic p, input logic c);
        check(tag, {2'b00, bus.rst_periph_no, bus.rst_core_no}, {2'b00, p, c});
    endtask

    task automatic chk_state(input string tag, input logic [2:0] s);
        check(tag, {1'b0, bus.seq_state_o}, {1'b0, s});
    endtask

    task automatic chk_cause(input string tag, input logic [3:0] c);
        check(tag, bus.rst_cause_o, c);
    endtask

    initial begin
        bus.pll_locked_i  = 1'b1;
        bus.sw_rst_req_i  = 1'b0;
        bus.dbg_rst_req_i = 1'b0;
        bus.wdog_kick_i   = 1'b1;
        bus.cause_clr_i   = 1'b0;

        // reset values
        tick_n(2);
        chk_rst("reset_outs", 1'b0, 1'b0);
        chk_cause("reset_cause", 4'h0);
        chk_state("reset_state", 3'd0);

        // release sequence, edge 1 is first edge after deassertion
        rst_sys_ni = 1'b1;
        tick_n(2);
        chk_state("rel_e2_wait", 3'd0);
        tick();
        chk_state("rel_e3_hold", 3'd1);
        chk_rst("rel_e3_outs", 1'b0, 1'b0);
        tick_n(7);
        chk_rst("rel_e10_outs", 1'b0, 1'b0);
        tick();
        chk_rst("rel_e11_periph", 1'b1, 1'b0);
        chk_state("rel_e11_state", 3'd2);
        tick_n(3);
        chk_rst("rel_e14_outs", 1'b1, 1'b0);
        tick();
        chk_rst("rel_e15_core", 1'b1, 1'b1);
        chk_state("rel_e15_run", 3'd3);

        // lock loss in RUN
        bus.pll_locked_i = 1'b0;
        tick();
        chk_rst("ll_e1_outs", 1'b1, 1'b1);
        tick();
        chk_rst("ll_e2_outs", 1'b1, 1'b1);
        tick();
        chk_rst("ll_e3_outs", 1'b0, 1'b0);
        chk_state("ll_state", 3'd0);
        chk_cause("ll_cause", 4'b0001);
        bus.pll_locked_i = 1'b1;
        tick_n(2);
        chk_state("ll_relock_wait", 3'd0);
        tick();
        chk_state("ll_relock_hold", 3'd1);
        tick_n(8);
        chk_rst("ll_relock_periph", 1'b1, 1'b0);
        tick_n(4);
        chk_rst("ll_relock_core", 1'b1, 1'b1);
        chk_state("ll_relock_run", 3'd3);
        chk_cause("ll_cause_sticky", 4'b0001);
        bus.cause_clr_i = 1'b1;
        tick();
        bus.cause_clr_i = 1'b0;
        chk_cause("clr_cause", 4'h0);

        // debug reset held 20 cycles
        bus.dbg_rst_req_i = 1'b1;
        tick();
        chk_state("dbg_state", 3'd4);
        chk_cause("dbg_cause", 4'b0100);
        chk_rst("dbg_outs_0", 1'b0, 1'b0);
        for (int i = 0; i < 19; i++) begin
            tick();
            chk_rst("dbg_outs_held", 1'b0, 1'b0);
        end
        chk_cause("dbg_cause_held", 4'b0100);
        bus.dbg_rst_req_i = 1'b0;
        tick();
        chk_state("dbg_exit_hold", 3'd1);
        tick_n(7);
        chk_rst("dbg_exit_e7", 1'b0, 1'b0);
        tick();
        chk_rst("dbg_exit_e8", 1'b1, 1'b0);
        tick_n(4);
        chk_state("dbg_back_run", 3'd3);
        bus.cause_clr_i = 1'b1;
        tick();
        bus.cause_clr_i = 1'b0;

        // software reset in RUN
        bus.sw_rst_req_i = 1'b1;
        tick();
        bus.sw_rst_req_i = 1'b0;
        chk_state("sw_state", 3'd1);
        chk_rst("sw_outs", 1'b0, 1'b0);
        chk_cause("sw_cause", 4'b0010);
        tick_n(7);
        chk_rst("sw_e7", 1'b0, 1'b0);
        tick();
        chk_rst("sw_e8_periph", 1'b1, 1'b0);
        tick_n(4);
        chk_state("sw_back_run", 3'd3);
        bus.cause_clr_i = 1'b1;
        tick();
        bus.cause_clr_i = 1'b0;
        chk_cause("sw_clr", 4'h0);

        // simultaneous sw + dbg in RUN
        bus.sw_rst_req_i  = 1'b1;
        bus.dbg_rst_req_i = 1'b1;
        tick();
        bus.sw_rst_req_i = 1'b0;
        chk_state("sim_state", 3'd4);
        chk_cause("sim_cause", 4'b0110);
        bus.dbg_rst_req_i = 1'b0;
        tick();
        chk_state("sim_exit_hold", 3'd1);
        tick_n(8);
        chk_state("sim_periph", 3'd2);
        // clear and new sw request together in PERIPH: set wins
        bus.sw_rst_req_i = 1'b1;
        bus.cause_clr_i  = 1'b1;
        tick();
        bus.sw_rst_req_i = 1'b0;
        bus.cause_clr_i  = 1'b0;
        chk_cause("set_beats_clr", 4'b0010);
        chk_state("set_beats_clr_st", 3'd1);
        bus.cause_clr_i = 1'b1;
        tick();
        bus.cause_clr_i = 1'b0;
        chk_cause("hold_clr", 4'h0);
        // sw request in HOLD is ignored
        bus.sw_rst_req_i = 1'b1;
        tick();
        bus.sw_rst_req_i = 1'b0;
        chk_state("sw_in_hold_st", 3'd1);
        chk_cause("sw_in_hold_cause", 4'h0);
        tick_n(5);
        chk_state("hold_cnt_zero", 3'd1);
        tick();
        chk_state("hold_to_periph", 3'd2);
        tick_n(4);
        chk_state("periph_to_run", 3'd3);

        // watchdog: kick every 10 cycles for 200 cycles
        bus.wdog_kick_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.wdog_kick_i = 1'b1;
            tick();
            bus.wdog_kick_i = 1'b0;
            tick_n(9);
            chk_state("wd_kicked_run", 3'd3);
        end
        chk_rst("wd_kicked_outs", 1'b1, 1'b1);
        // stop kicking
        bus.wdog_kick_i = 1'b1;
        tick();
        bus.wdog_kick_i = 1'b0;
        tick_n(15);
        chk_state("wd_k15_run", 3'd3);
        tick();
        chk_state("wd_k16_state", WdogOn ? 3'd1 : 3'd3);
        chk_rst("wd_k16_outs", !WdogOn, !WdogOn);
        chk_cause("wd_cause", WdogOn ? 4'b1000 : 4'b0000);
        tick_n(12);
        chk_state("wd_recover_run", 3'd3);
        // kick in the expiry cycle
        bus.wdog_kick_i = 1'b1;
        tick();
        bus.wdog_kick_i = 1'b0;
        tick_n(15);
        bus.wdog_kick_i = 1'b1;
        tick();
        bus.wdog_kick_i = 1'b0;
        chk_state("wd_late_kick_run", 3'd3);
        chk_rst("wd_late_kick_outs", 1'b1, 1'b1);
        tick_n(10);
        chk_state("wd_after_late_kick", 3'd3);
        chk_cause("wd_cause_kept", WdogOn ? 4'b1000 : 4'b0000);
        bus.wdog_kick_i = 1'b1;

        // asynchronous reset assertion, no clock edge needed
        rst_sys_ni = 1'b0;
        #2;
        chk_rst("async_rst_outs", 1'b0, 1'b0);
        chk_state("async_rst_state", 3'd0);
        chk_cause("async_rst_cause", 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Staged reset controller between the board clock generator and the Ibex demo system. It qualifies the PLL `locked` indication and holds the system in reset for a programmable settle time. It then releases peripheral reset before core reset. Afterwards it re-sequences on PLL lock loss, software reset request, debug-module reset request or watchdog expiry, and records the cause in a sticky register.

## Interface
- `HoldCycles`, 1024: cycles both resets stay asserted after lock is qualified; ≥1.
- `StageGap`, 16: cycles between peripheral and core reset release; ≥1.
- `WdogCycles`, 2**24: watchdog timeout in RUN; ≥2; used only with watchdog compiled in.
- `clk_sys_i`  in  1  system clock.
- `rst_sys_ni`  in  1  asynchronous, active-low reset for all flops in this block.
- `pll_locked_i`  in  1  PLL lock; asynchronous to `clk_sys_i`; 2-flop synchronized.
- `sw_rst_req_i`  in  1  single-cycle software reset request.
- `dbg_rst_req_i`  in  1  level debug reset (ndmreset); holds both resets while high.
- `wdog_kick_i`  in  1  single-cycle watchdog kick.
- `cause_clr_i`  in  1  clears `rst_cause_o`.
- `rst_periph_no`  out  1  peripheral reset, active-low, registered.
- `rst_core_no`  out  1  core reset, active-low, registered.
- `rst_cause_o`  out  4  sticky cause: [0] lock loss, [1] sw, [2] dbg, [3] wdog.
- `seq_state_o`  out  3  current state encoding, for debug.

## Operation
- States, with encodings: WAIT_LOCK=0, HOLD=1, PERIPH=2, RUN=3, DBG=4.
- Reset values while `rst_sys_ni`=0:
  - State is WAIT_LOCK.
  - `rst_periph_no`=0, `rst_core_no`=0, `rst_cause_o`=0, `seq_state_o`=0.
  - Counters and synchronizer are 0.
- Asserting `rst_sys_ni` drives both reset outputs low asynchronously. All releases are synchronous to `clk_sys_i`.
- WAIT_LOCK: both resets low. When `locked_sync`=1, go to HOLD and load the counter with `HoldCycles-1`.
- HOLD: both resets low. The counter decrements each cycle. At 0, go to PERIPH with `rst_periph_no`=1 and load the counter with `StageGap-1`.
- PERIPH: `rst_periph_no`=1, `rst_core_no`=0. At counter 0, go to RUN with `rst_core_no`=1.
- RUN: both resets high.
- DBG: both resets low. When `dbg_rst_req_i`=0, go to HOLD.
- Exit events, from any state other than WAIT_LOCK, in priority order (highest first):
  - `locked_sync`=0: go to WAIT_LOCK and set cause[0]. This also applies during HOLD, PERIPH and DBG.
  - `dbg_rst_req_i`=1: go to DBG and set cause[2] on entry only.
  - Watchdog expiry, RUN only: go to HOLD and set cause[3].
  - `sw_rst_req_i`=1, in PERIPH or RUN: go to HOLD and set cause[1].
- Simultaneous events: only the highest-priority event transitions the state, but every present event sets its cause bit.
- `sw_rst_req_i` in WAIT_LOCK, HOLD or DBG is ignored and sets no cause bit.
- Reset outputs change on the same edge as the state transition; entering a reset-asserting state drives both low on that edge.
- Cause bits are sticky and are cleared only by `cause_clr_i` or `rst_sys_ni`. If set and clear occur in the same cycle, set wins. The cause register is not affected by internal sequencing.
- Counter width is `$clog2(max(HoldCycles, StageGap)+1)`. It never underflows; the counter is reloaded on every state entry.

## Timing
- `pll_locked_i` to `locked_sync` latency: 2 cycles.
- Release sequence, with `pll_locked_i` high before `rst_sys_ni` deasserts; edge 1 is the first edge after deassertion:
  - `locked_sync` valid after edge 2.
  - HOLD entered at edge 3.
  - `rst_periph_no` rises at edge 3+HoldCycles.
  - `rst_core_no` rises at edge 3+HoldCycles+StageGap.
- Lock loss in RUN: both resets fall 3 edges after `pll_locked_i` falls (2 sync + 1 state).
- `sw_rst_req_i` or `dbg_rst_req_i` sampled high at edge N: resets low after edge N. After a sw reset, `rst_periph_no` rises at edge N+HoldCycles.
- Watchdog: counter cleared on RUN entry and on `wdog_kick_i`; increments once per RUN cycle. Expiry occurs when the count equals `WdogCycles-1` and `wdog_kick_i`=0. A kick in the expiry cycle wins.

## Configuration
- `RST_SEQ_WDOG_EN` defined: watchdog counter and expiry path present as described.
- `RST_SEQ_WDOG_EN` undefined:
  - No watchdog counter; `wdog_kick_i` ignored.
  - cause[3] tied 0; `WdogCycles` unused.
  - All other behaviour is identical.

## Test plan
- Release: HoldCycles=8, StageGap=4, locked high, deassert `rst_sys_ni` → `rst_periph_no` rises at edge 11, `rst_core_no` at edge 15, `seq_state_o`=3 after edge 15.
- Lock loss: in RUN, drop `pll_locked_i` → both resets low 3 edges later, cause=4'b0001, state=0. Restore lock → full sequence repeats; cause still 4'b0001.
- Debug reset: in RUN, hold `dbg_rst_req_i` 20 cycles → resets low throughout, cause[2]=1. Release → `rst_periph_no` rises 8 edges after the DBG exit edge.
- Simultaneous events: assert `sw_rst_req_i` and `dbg_rst_req_i` in the same cycle in RUN → state=4, cause=4'b0110. Assert `cause_clr_i` with a new sw request in PERIPH → cause[1] remains 1.
- Watchdog (macro on, WdogCycles=16):
  - Kick every 10 cycles for 200 cycles → no reset.
  - Stop kicking → resets low 16 cycles after the last kick, cause[3]=1.
  - Kick in the expiry cycle → no reset.
- Macro off: same stimulus as the watchdog scenario → no reset ever, cause[3]=0.
